aes_key_expander: RTL and testbench

- Iterative, parametrised AES key expander. Generates the full key schedule for 128/192/256-bit keys, one 32-bit word per clock.
- Stores all round keys in an internal flop array and serves any round key by index, in encrypt or decrypt (reversed) order.
- Sits between the key-load interface and the round datapath. Replaces per-round combinational key scheduling.

---
 rtl/aes_key_expander.sv | 172 +++++++++++++++++
 tb/tb_aes_key_expander.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expander.sv
// rtl/aes_key_expander.sv - iterative AES-128/192/256 key schedule with indexed round-key store
// Define AES_KEY_ZEROIZE_EN to add the zeroize input that wipes all key material.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] b;
    p = 8'h00;
    b = x;
    for (int k = 0; k < 8; k++) begin
      if (y[k]) p = p ^ b;
      b = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] inv;

  // Multiplicative inverse as a^254 (maps 0 to 0), then the affine transform.
  always_comb begin
    inv = a;
    for (int k = 0; k < 6; k++) inv = gf_mul(gf_mul(inv, inv), a);
    inv = gf_mul(inv, inv);
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module aes_key_expander #(
  parameter int KEY_SIZE = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [KEY_SIZE-1:0] key_in,
  input  logic                start,
`ifdef AES_KEY_ZEROIZE_EN
  input  logic                zeroize,
`endif
  output logic                busy,
  output logic                keys_valid,
  input  logic                rk_rd_en,
  input  logic [3:0]          rk_rd_idx,
  input  logic                rk_rd_dec,
  output logic [127:0]        rk_rd_data
);
  localparam int NK = KEY_SIZE / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  if (KEY_SIZE != 128 && KEY_SIZE != 192 && KEY_SIZE != 256) begin : g_bad_key_size
    $error("aes_key_expander: KEY_SIZE must be 128, 192 or 256");
  end

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_t;
  state_t state, state_nxt;

  logic [31:0] store [NW];
  logic [31:0] win [NK];   // last NK words: win[0] = w[i-NK], win[NK-1] = w[i-1]
  logic [5:0]  wr_idx;
  logic [2:0]  phase;      // i mod NK
  logic [7:0]  rcon;
  logic        zero;

`ifdef AES_KEY_ZEROIZE_EN
  assign zero = zeroize;
`else
  assign zero = 1'b0;
`endif

  logic [31:0] prev, sub_in, sub_out, temp, new_word;
  logic [3:0]  rd_round;

  assign prev   = win[NK-1];
  assign sub_in = (phase == 3'd0) ? {prev[7:0], prev[31:8]} : prev;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (.a(sub_in[8*b +: 8]), .s(sub_out[8*b +: 8]));
  end

  always_comb begin
    temp = prev;
    if (phase == 3'd0) temp = sub_out ^ {24'h0, rcon};
    else if (NK == 8 && phase == 3'd4) temp = sub_out;
  end

  assign new_word = win[0] ^ temp;
  assign rd_round = rk_rd_dec ? (4'(NR) - rk_rd_idx) : rk_rd_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = start ? LOAD : IDLE;
      LOAD:       state_nxt = EXPAND;
      EXPAND:     if (wr_idx == 6'(NW - 1)) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
    if (zero) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      keys_valid <= 1'b0;
      wr_idx     <= '0;
      phase      <= '0;
      rcon       <= 8'h01;
      for (int k = 0; k < NW; k++) store[k] <= '0;
      for (int k = 0; k < NK; k++) win[k] <= '0;
    end else if (zero) begin
      busy       <= 1'b0;
      keys_valid <= 1'b0;
      wr_idx     <= '0;
      phase      <= '0;
      rcon       <= 8'h00;
      for (int k = 0; k < NW; k++) store[k] <= '0;
      for (int k = 0; k < NK; k++) win[k] <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            busy       <= 1'b1;
            keys_valid <= 1'b0;
          end
        end
        LOAD: begin
          for (int k = 0; k < NK; k++) begin
            store[k] <= key_in[32*k +: 32];
            win[k]   <= key_in[32*k +: 32];
          end
          wr_idx <= 6'(NK);
          phase  <= 3'd0;
          rcon   <= 8'h01;
        end
        EXPAND: begin
          store[wr_idx] <= new_word;
          for (int k = 0; k < NK - 1; k++) win[k] <= win[k+1];
          win[NK-1] <= new_word;
          wr_idx    <= wr_idx + 6'd1;
          phase     <= (phase == 3'(NK - 1)) ? 3'd0 : phase + 3'd1;
          if (phase == 3'd0) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
          if (wr_idx == 6'(NW - 1)) begin
            busy       <= 1'b0;
            keys_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Reads sample keys_valid before any same-cycle re-key takes effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_rd_data <= '0;
    end else if (zero) begin
      rk_rd_data <= '0;
    end else if (rk_rd_en) begin
      if (keys_valid && rk_rd_idx <= 4'(NR))
        rk_rd_data <= {store[{rd_round, 2'd3}], store[{rd_round, 2'd2}],
                       store[{rd_round, 2'd1}], store[{rd_round, 2'd0}]};
      else
        rk_rd_data <= '0;
    end
  end
endmodule

// File: tb/tb_aes_key_expander.sv
// tb/tb_aes_key_expander.sv - directed FIPS-197 vector bench for aes_key_expander (all key sizes)
module tb_aes_key_expander;
  localparam logic [127:0] KEY128  = 128'h3c4fcf09_8815f7ab_a6d2ae28_16157e2b;
  localparam logic [127:0] RK1     = 128'h05766c2a_3939a323_b12c5488_17fefaa0;
  localparam logic [127:0] RK10    = 128'ha60c63b6_c80c3fe1_8925eec9_a8f914d0;
  localparam logic [127:0] KEYC1   = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
  localparam logic [127:0] RK10C1  = 128'hc5302b4d_8ba707f3_174a94e3_7f1d1113;
  localparam logic [191:0] KEY192  = 192'h7b6b2c52_d2eaf862_e5799080_2bf310c8_52640eda_f7b0738e;
  localparam logic [255:0] KEY256  = 256'hf4df1409_a310982d_d708613b_072c351f_81777d85_f0ae732b_be71ca15_10eb3d60;
  localparam logic [31:0]  W51     = 32'h02220001;
  localparam logic [31:0]  W59     = 32'h1e636c70;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic rd_en = 1'b0;
  logic [3:0] rd_idx = 4'd0;
  logic rd_dec = 1'b0;
  logic [127:0] key128 = KEY128;
  logic [191:0] key192 = KEY192;
  logic [255:0] key256 = KEY256;
  logic busy128, busy192, busy256, kv128, kv192, kv256;
  logic [127:0] data128, data192, data256;
`ifdef AES_KEY_ZEROIZE_EN
  logic zeroize = 1'b0;
`endif

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  aes_key_expander #(.KEY_SIZE(128)) u_dut128 (
    .clk(clk), .rst_n(rst_n), .key_in(key128), .start(start),
`ifdef AES_KEY_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .busy(busy128), .keys_valid(kv128), .rk_rd_en(rd_en), .rk_rd_idx(rd_idx),
    .rk_rd_dec(rd_dec), .rk_rd_data(data128));

  aes_key_expander #(.KEY_SIZE(192)) u_dut192 (
    .clk(clk), .rst_n(rst_n), .key_in(key192), .start(start),
`ifdef AES_KEY_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .busy(busy192), .keys_valid(kv192), .rk_rd_en(rd_en), .rk_rd_idx(rd_idx),
    .rk_rd_dec(rd_dec), .rk_rd_data(data192));

  aes_key_expander #(.KEY_SIZE(256)) u_dut256 (
    .clk(clk), .rst_n(rst_n), .key_in(key256), .start(start),
`ifdef AES_KEY_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .busy(busy256), .keys_valid(kv256), .rk_rd_en(rd_en), .rk_rd_idx(rd_idx),
    .rk_rd_dec(rd_dec), .rk_rd_data(data256));

  task automatic do_read(input logic [3:0] idx, input logic dec);
    @(negedge clk);
    rd_en = 1'b1; rd_idx = idx; rd_dec = dec;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  // Latency = posedges after the one that samples start, until keys_valid is seen high.
  task automatic expand_all(output int l128, output int l192, output int l256);
    int cnt;
    l128 = -1; l192 = -1; l256 = -1; cnt = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(posedge clk); cnt = 1; #1;
    while ((l128 < 0 || l192 < 0 || l256 < 0) && cnt < 100) begin
      if (kv128 && l128 < 0) l128 = cnt;
      if (kv192 && l192 < 0) l192 = cnt;
      if (kv256 && l256 < 0) l256 = cnt;
      @(posedge clk); cnt++; #1;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_checks++; if ({busy128, kv128} !== 2'b00) $display("FAIL reset_flags128 got %b want 00", {busy128, kv128}); else n_pass++;
    n_checks++; if ({busy192, kv192, busy256, kv256} !== 4'b0) $display("FAIL reset_flags192_256 got %b want 0000", {busy192, kv192, busy256, kv256}); else n_pass++;
    n_checks++; if (data128 !== 128'h0) $display("FAIL reset_data128 got %h want 0", data128); else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_read_invalid;
    do_read(4'd0, 1'b0);
    n_checks++; if (data128 !== 128'h0) $display("FAIL read_not_valid got %h want 0", data128); else n_pass++;
  endtask

  task automatic test_expand;
    int l128, l192, l256;
    expand_all(l128, l192, l256);
    n_checks++; if (l128 != 41) $display("FAIL latency128 got %0d want 41", l128); else n_pass++;
    n_checks++; if (l192 != 47) $display("FAIL latency192 got %0d want 47", l192); else n_pass++;
    n_checks++; if (l256 != 53) $display("FAIL latency256 got %0d want 53", l256); else n_pass++;
    n_checks++; if ({busy128, busy192, busy256} !== 3'b000) $display("FAIL busy_after_done got %b want 000", {busy128, busy192, busy256}); else n_pass++;
  endtask

  task automatic test_round_keys;
    do_read(4'd1, 1'b0);
    n_checks++; if (data128 !== RK1) $display("FAIL rk1_128 got %h want %h", data128, RK1); else n_pass++;
    n_checks++; if (data256 !== KEY256[255:128]) $display("FAIL rk1_256 got %h want %h", data256, KEY256[255:128]); else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++; if (data128 !== RK1) $display("FAIL rd_hold got %h want %h", data128, RK1); else n_pass++;
    do_read(4'd10, 1'b0);
    n_checks++; if (data128 !== RK10) $display("FAIL rk10_128 got %h want %h", data128, RK10); else n_pass++;
    do_read(4'd0, 1'b0);
    n_checks++; if (data128 !== KEY128) $display("FAIL rk0_128 got %h want %h", data128, KEY128); else n_pass++;
    n_checks++; if (data192 !== KEY192[127:0]) $display("FAIL rk0_192 got %h want %h", data192, KEY192[127:0]); else n_pass++;
    do_read(4'd0, 1'b1);
    n_checks++; if (data128 !== RK10) $display("FAIL dec0_128 got %h want %h", data128, RK10); else n_pass++;
    n_checks++; if (data192[127:96] !== W51) $display("FAIL w51_192 got %h want %h", data192[127:96], W51); else n_pass++;
    n_checks++; if (data256[127:96] !== W59) $display("FAIL w59_256 got %h want %h", data256[127:96], W59); else n_pass++;
    do_read(4'd10, 1'b1);
    n_checks++; if (data128 !== KEY128) $display("FAIL dec10_128 got %h want %h", data128, KEY128); else n_pass++;
    do_read(4'd11, 1'b0);
    n_checks++; if (data128 !== 128'h0) $display("FAIL idx11_128 got %h want 0", data128); else n_pass++;
    do_read(4'd13, 1'b0);
    n_checks++; if (data192 !== 128'h0) $display("FAIL idx13_192 got %h want 0", data192); else n_pass++;
    do_read(4'd15, 1'b0);
    n_checks++; if (data256 !== 128'h0) $display("FAIL idx15_256 got %h want 0", data256); else n_pass++;
  endtask

  // Re-key with a same-cycle read of the old store and a start pulse ignored mid-expansion.
  task automatic test_rekey_busy;
    key128 = KEYC1;
    @(negedge clk);
    start = 1'b1; rd_en = 1'b1; rd_idx = 4'd10; rd_dec = 1'b0;
    @(negedge clk);
    start = 1'b0; rd_en = 1'b0;
    n_checks++; if (data128 !== RK10) $display("FAIL read_at_rekey got %h want %h", data128, RK10); else n_pass++;
    n_checks++; if ({busy128, kv128} !== 2'b10) $display("FAIL rekey_drop got %b want 10", {busy128, kv128}); else n_pass++;
    repeat (9) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    n_checks++; if (kv128 !== 1'b0) $display("FAIL kv_early got %b want 0", kv128); else n_pass++;
    @(negedge clk);
    n_checks++; if (kv128 !== 1'b1) $display("FAIL kv_at_41 got %b want 1", kv128); else n_pass++;
    do_read(4'd10, 1'b0);
    n_checks++; if (data128 !== RK10C1) $display("FAIL rk10_rekey got %h want %h", data128, RK10C1); else n_pass++;
  endtask

  task automatic test_reset_mid_expand;
    int l128, l192, l256;
    repeat (60) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++; if ({busy128, kv128, busy256, kv256} !== 4'b0) $display("FAIL midreset_flags got %b want 0000", {busy128, kv128, busy256, kv256}); else n_pass++;
    n_checks++; if (data128 !== 128'h0) $display("FAIL midreset_data got %h want 0", data128); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    expand_all(l128, l192, l256);
    n_checks++; if (l128 != 41) $display("FAIL latency_after_reset got %0d want 41", l128); else n_pass++;
    do_read(4'd0, 1'b1);
    n_checks++; if (data128 !== RK10C1) $display("FAIL rk10_after_reset got %h want %h", data128, RK10C1); else n_pass++;
  endtask

`ifdef AES_KEY_ZEROIZE_EN
  task automatic test_zeroize;
    @(negedge clk);
    zeroize = 1'b1; start = 1'b1; rd_en = 1'b1; rd_idx = 4'd10; rd_dec = 1'b0;
    @(negedge clk);
    zeroize = 1'b0; start = 1'b0; rd_en = 1'b0;
    n_checks++; if ({busy128, kv128} !== 2'b00) $display("FAIL zeroize_flags got %b want 00", {busy128, kv128}); else n_pass++;
    n_checks++; if (data128 !== 128'h0) $display("FAIL zeroize_data got %h want 0", data128); else n_pass++;
    do_read(4'd0, 1'b0);
    n_checks++; if ({busy128, data128} !== 129'h0) $display("FAIL zeroize_read got %h want 0", {busy128, data128}); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_read_invalid();
    test_expand();
    test_round_keys();
    test_rekey_busy();
    test_reset_mid_expand();
`ifdef AES_KEY_ZEROIZE_EN
    test_zeroize();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
